// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state type and default operand width
package serial_subtractor_pkg;
  localparam int DEFAULT_NUM_BITS = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_subtractor_fullsub.sv
// fullsub_1bit: combinational one-bit full subtractor
module fullsub_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);
  assign diff = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per cycle
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out,
  output logic                overflow
);
  localparam int CW = $clog2(NUM_BITS) + 1;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [NUM_BITS-1:0] a_sr, b_sr, d_sr;
  logic brw, a_msb, b_msb, fd, fb, last;
  assign last = cnt == CW'(NUM_BITS - 1);
  fullsub_1bit u_fs (
    .a(a_sr[0]),
    .b(b_sr[0]),
    .borrow_in(brw),
    .diff(fd),
    .borrow_out(fb)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : next_state;
  always_comb
    next_state = state == IDLE  ? (start ? SHIFT : IDLE) :
                 state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  always_comb begin
    busy = state == SHIFT;
    done = state == DONE;
  end
  // results are published only on the final shift, so partial sums never show
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      brw <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff <= '0;
      borrow_out <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr <= a;
      b_sr <= b;
      a_msb <= a[NUM_BITS-1];
      b_msb <= b[NUM_BITS-1];
      brw <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= {fd, d_sr[NUM_BITS-1:1]};
      brw <= fb;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff <= {fd, d_sr[NUM_BITS-1:1]};
        borrow_out <= fb;
        overflow <= (a_msb != b_msb) && (fd != a_msb);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: arithmetic reference model plus directed literal checks
module tb_serial_subtractor;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic busy, done, borrow_out, overflow;
  logic [N-1:0] diff;
  serial_subtractor #(.NUM_BITS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  int e = 0, acc = -1000, ncyc = 0, dones = 0;
  int done_t[$];
  bit chk = 0;
  logic [N-1:0] pd, md = '0;
  logic pb, pv, mb = 1'b0, mv = 1'b0;
  task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, ncyc);
    end
  endtask
  // model: an op accepted at edge k is busy for edges k..k+N-1 and done at k+N
  always @(posedge clk) begin
    e++;
    if (rst) begin
      acc = -1000;
      md = '0;
      mb = 1'b0;
      mv = 1'b0;
    end else begin
      if (start && e >= acc + N + 2) begin
        acc = e;
        pd = a - b;
        pb = a < b;
        pv = (a[N-1] != b[N-1]) && (pd[N-1] != a[N-1]);
      end
      if (e == acc + N) begin
        md = pd;
        mb = pb;
        mv = pv;
      end
    end
  end
  always @(negedge clk) begin
    ncyc++;
    if (done) begin
      dones++;
      done_t.push_back(ncyc);
    end
    if (chk) begin
      chk1("busy", busy, e >= acc && e < acc + N);
      chk1("done", done, e == acc + N);
      chk1("diff", diff, md);
      chk1("borrow_out", borrow_out, mb);
      chk1("overflow", overflow, mv);
    end
  end
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] ed, input logic eb, input logic ev);
    int n;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk1("latency", n, N + 1);
    chk1("lit_diff", diff, ed);
    chk1("lit_borrow", borrow_out, eb);
    chk1("lit_overflow", overflow, ev);
  endtask
  initial begin
    int n, d0, t0;
    repeat (2) @(negedge clk);
    chk = 1;
    chk1("rst_busy", busy, 0);
    chk1("rst_done", done, 0);
    chk1("rst_diff", diff, 0);
    rst = 1'b0;
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    // second start mid-shift must be dropped
    @(negedge clk);
    a = 8'h50;
    b = 8'h20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = dones;
    repeat (2) @(negedge clk);
    a = 8'h11;
    b = 8'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk1("ignore_diff", diff, 8'h30);
    repeat (12) @(negedge clk);
    chk1("ignore_done_count", dones - d0, 1);
    // abort on the 4th shift cycle
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("abort_busy", busy, 0);
    chk1("abort_done", done, 0);
    chk1("abort_diff", diff, 0);
    chk1("abort_borrow", borrow_out, 0);
    chk1("abort_overflow", overflow, 0);
    d0 = dones;
    repeat (12) @(negedge clk);
    chk1("abort_no_done", dones - d0, 0);
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    // continuous start with operands churning every cycle
    @(negedge clk);
    t0 = done_t.size();
    start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (14) @(negedge clk);
    if (done_t.size() >= t0 + 3) begin
      chk1("period_1", done_t[t0+1] - done_t[t0], N + 2);
      chk1("period_2", done_t[t0+2] - done_t[t0+1], N + 2);
    end else begin
      chk1("held_done_count", done_t.size() - t0, 3);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
